// File: rtl/serial_pkg.sv
// serial_pkg: shared state encoding and counter sizing for the bit-serial adder/subtractor
package serial_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  typedef enum logic [1:0] {S_IDLE = ST_IDLE, S_SHIFT = ST_SHIFT, S_DONE = ST_DONE} state_t;
  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/serial_addsub_full_adder_bit.sv
// full_adder_bit: 1-bit full adder assembled from the 2-input gate library cells
module xor2 (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a ^ b;
endmodule

module and2 (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a & b;
endmodule

module or2 (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a | b;
endmodule

module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic p, g, t;
  xor2 u_x0 (.a(a),   .b(b),   .y(p));
  xor2 u_x1 (.a(p),   .b(cin), .y(s));
  and2 u_a0 (.a(a),   .b(b),   .y(g));
  and2 u_a1 (.a(cin), .b(p),   .y(t));
  or2  u_o0 (.a(g),   .b(t),   .y(cout));
endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: LSB-first bit-serial add/sub, one bit per clock; SERIAL_ADDSUB_OVF_EN adds signed overflow
module serial_addsub
  import serial_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDSUB_OVF_EN
  ,
`else
  ,
`endif
  output logic             ovf
);
  localparam int CW = cnt_w(WIDTH);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, sum_q, sum_d;
  logic c_q, c_d, cout_q, cout_d;
  logic fa_s, fa_c, last;
  full_adder_bit u_fa (.a(a_q[0]), .b(b_q[0]), .cin(c_q), .s(fa_s), .cout(fa_c));
  assign last = (state_q == S_SHIFT) && (cnt_q == CW'(WIDTH - 1));
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    c_d     = c_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      S_IDLE: if (start) begin
        a_d     = a;
        b_d     = sub ? ~b : b;
        c_d     = sub;
        cnt_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        r_d     = {fa_s, r_q[WIDTH-1:1]};
        c_d     = fa_c;
        cnt_d   = cnt_q + 1'b1;
        state_d = last ? S_DONE : S_SHIFT;
        sum_d   = last ? r_d : sum_q;
        cout_d  = last ? fa_c : cout_q;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      c_q     <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end
`ifdef SERIAL_ADDSUB_OVF_EN
  // c_q on the last step is the carry into the MSB
  logic ovf_q, ovf_d;
  assign ovf_d = last ? (c_q ^ fa_c) : ovf_q;
  always_ff @(posedge clk) ovf_q <= rst ? 1'b0 : ovf_d;
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif
  assign busy = (state_q == S_SHIFT);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: directed vectors with a done-triggered scoreboard monitor
module tb_serial_addsub;
  localparam int W = 4;
`ifdef SERIAL_ADDSUB_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, sub = 1'b0;
  logic [W-1:0] a = '0, b = '0, sum;
  logic busy, done, cout, ovf;
  logic [W+1:0] exp_q[$];
  int checks = 0, errors = 0;

  serial_addsub #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_done", 8'd1, 8'd0);
      else chk("result{sum,cout,ovf}", 8'({sum, cout, ovf}), 8'(exp_q.pop_front()));
    end
  end

  task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts,
                    input logic [W-1:0] es, input logic ec, input logic eo);
    a = ta; b = tb_; sub = ts; start = 1'b1;
    exp_q.push_back({es, ec, eo & OVF_ON});
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= W; i++) begin
      chk("busy_phase{busy,done}", 8'({busy, done}), 8'b10);
      @(negedge clk);
    end
    chk("done_phase{busy,done}", 8'({busy, done}), 8'b01);
    @(negedge clk);
    chk("idle_after{busy,done}", 8'({busy, done}), 8'b00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_state{busy,done,sum,cout,ovf}", 8'({busy, done, sum, cout, ovf}), 8'd0);
    op(4'd3,  4'd5, 1'b0, 4'd8,  1'b0, 1'b1);
    op(4'd15, 4'd1, 1'b0, 4'd0,  1'b1, 1'b0);
    op(4'd5,  4'd3, 1'b1, 4'd2,  1'b1, 1'b0);
    op(4'd3,  4'd5, 1'b1, 4'd14, 1'b0, 1'b0);
    op(4'd8,  4'd1, 1'b1, 4'd7,  1'b1, 1'b1);
    op(4'd15, 4'd15, 1'b0, 4'd14, 1'b1, 1'b0);
    op(4'd6,  4'd6, 1'b1, 4'd0,  1'b1, 1'b0);
    op(4'd9,  4'd0, 1'b1, 4'd9,  1'b1, 1'b0);
    // starts during SHIFT (cycle 2) and DONE (cycle 5) must be dropped
    a = 4'd1; b = 4'd1; sub = 1'b0; start = 1'b1;
    exp_q.push_back({4'd2, 1'b0, 1'b0});
    @(negedge clk); start = 1'b0;
    @(negedge clk); a = 4'd7; b = 4'd7; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); start = 1'b1;
    chk("done_cycle5", 8'(done), 8'd1);
    @(negedge clk); start = 1'b0;
    chk("idle_cycle6{busy,done}", 8'({busy, done}), 8'b00);
    op(4'd7, 4'd7, 1'b0, 4'd14, 1'b0, 1'b1);
    // reset mid-operation discards the partial result
    a = 4'd9; b = 4'd9; sub = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("rst_test_busy", 8'(busy), 8'd1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("after_rst{busy,done,sum,cout,ovf}", 8'({busy, done, sum, cout, ovf}), 8'd0);
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      chk("after_rst_quiet{busy,done}", 8'({busy, done}), 8'b00);
    end
    op(4'd2, 4'd3, 1'b0, 4'd5, 1'b0, 1'b0);
    @(negedge clk);
    chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
